// File: rtl/decode_cycle.sv
// ID stage: register file with write-first bypass, main/ALU decode, immediate extend, ID/EX register.
// Latency: 1 cycle, InstrD sampled at edge N is visible on the E outputs right after edge N.
// Backpressure: none; FlushE turns the next ID/EX load into an all-zero bubble, no stall input.
module decode_cycle #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] InstrD,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic                  FlushE,
    output logic                  RegWriteE,
    output logic [1:0]            ResultSrcE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic [2:0]            ALUControlE,
    output logic                  ALUSrcE,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [REG_ADDR_W-1:0] Rs1E,
    output logic [REG_ADDR_W-1:0] Rs2E,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] PCPlus4E
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4
    } immSrcT;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluOpT;

    typedef struct packed {
        logic                  regWrite;
        logic [1:0]            resultSrc;
        logic                  memWrite;
        logic                  jump;
        logic                  branch;
        logic [2:0]            aluControl;
        logic                  aluSrc;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] immExt;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pcPlus4;
    } idExT;

    logic [DATA_WIDTH-1:0] regFile [NUM_REGS];

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;

    logic                  regWrite;
    logic [1:0]            resultSrc;
    logic                  memWrite;
    logic                  jump;
    logic                  branch;
    logic                  aluSrc;
    immSrcT                immSrc;
    aluOpT                 aluOp;
    logic [2:0]            aluControl;
    logic [DATA_WIDTH-1:0] immExt;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic                  wbCommit;

    idExT idExNext;
    idExT idExQ;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];
    assign rs1      = InstrD[19:15];
    assign rs2      = InstrD[24:20];
    assign rd       = InstrD[11:7];

    // A write-back only lands when enabled and not aimed at x0; reset suppresses it in the regfile process.
    assign wbCommit = RegWriteW && (RdW != '0);

    // Register file storage: cleared on reset, otherwise takes the write-back (FlushE does not gate it).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= '0;
            end
        end else if (wbCommit) begin
            regFile[RdW] <= ResultW;
        end
    end

    // Read ports: x0 hard-wired to zero, same-cycle write-back forwarded ahead of the stored value.
    always_comb begin
        rd1 = regFile[rs1];
        rd2 = regFile[rs2];
        if (rs1 == '0) begin
            rd1 = '0;
        end else if (wbCommit && (RdW == rs1)) begin
            rd1 = ResultW;
        end
        if (rs2 == '0) begin
            rd2 = '0;
        end else if (wbCommit && (RdW == rs2)) begin
            rd2 = ResultW;
        end
    end

    // Main decoder: unknown opcodes fall through to the all-zero bubble.
    always_comb begin
        regWrite  = 1'b0;
        resultSrc = 2'b00;
        memWrite  = 1'b0;
        jump      = 1'b0;
        branch    = 1'b0;
        aluSrc    = 1'b0;
        immSrc    = IMM_NONE;
        aluOp     = ALUOP_ADD;
        case (opcode)
            OP_LW: begin
                regWrite  = 1'b1;
                immSrc    = IMM_I;
                aluSrc    = 1'b1;
                resultSrc = 2'b01;
            end
            OP_SW: begin
                immSrc   = IMM_S;
                aluSrc   = 1'b1;
                memWrite = 1'b1;
            end
            OP_RTYP: begin
                regWrite = 1'b1;
                aluOp    = ALUOP_FUNCT;
            end
            OP_BEQ: begin
                immSrc = IMM_B;
                branch = 1'b1;
                aluOp  = ALUOP_SUB;
            end
            OP_IALU: begin
                regWrite = 1'b1;
                immSrc   = IMM_I;
                aluSrc   = 1'b1;
                aluOp    = ALUOP_FUNCT;
            end
            OP_JAL: begin
                regWrite  = 1'b1;
                immSrc    = IMM_J;
                resultSrc = 2'b10;
                jump      = 1'b1;
            end
            default: begin
                regWrite = 1'b0;
            end
        endcase
    end

    // ALU decoder: subtraction only for R-type with funct7[5] set (addi never subtracts).
    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_ADD: aluControl = ALU_ADD;
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  aluControl = (opcode[5] && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControl = ALU_SLT;
                    3'b110:  aluControl = ALU_OR;
                    3'b111:  aluControl = ALU_AND;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

    // Immediate extender: every format sign-extends from InstrD[31].
    always_comb begin
        immExt = '0;
        case (immSrc)
            IMM_I:   immExt = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   immExt = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   immExt = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   immExt = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: immExt = '0;
        endcase
    end

    // Gather everything the execute stage needs into one word.
    always_comb begin
        idExNext            = '0;
        idExNext.regWrite   = regWrite;
        idExNext.resultSrc  = resultSrc;
        idExNext.memWrite   = memWrite;
        idExNext.jump       = jump;
        idExNext.branch     = branch;
        idExNext.aluControl = aluControl;
        idExNext.aluSrc     = aluSrc;
        idExNext.rd1        = rd1;
        idExNext.rd2        = rd2;
        idExNext.immExt     = immExt;
        idExNext.rs1        = rs1;
        idExNext.rs2        = rs2;
        idExNext.rd         = rd;
        idExNext.pc         = PCD;
        idExNext.pcPlus4    = PCPlus4D;
    end

    // ID/EX register: reset and flush both load a full bubble, reset taking priority.
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            idExQ <= '0;
        end else begin
            idExQ <= idExNext;
        end
    end

    assign RegWriteE   = idExQ.regWrite;
    assign ResultSrcE  = idExQ.resultSrc;
    assign MemWriteE   = idExQ.memWrite;
    assign JumpE       = idExQ.jump;
    assign BranchE     = idExQ.branch;
    assign ALUControlE = idExQ.aluControl;
    assign ALUSrcE     = idExQ.aluSrc;
    assign RD1E        = idExQ.rd1;
    assign RD2E        = idExQ.rd2;
    assign ImmExtE     = idExQ.immExt;
    assign Rs1E        = idExQ.rs1;
    assign Rs2E        = idExQ.rs2;
    assign RdE         = idExQ.rd;
    assign PCE         = idExQ.pc;
    assign PCPlus4E    = idExQ.pcPlus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed sequence followed by randomized traffic.
// Latency: expects each driven cycle to appear on the E outputs one edge later.
// Backpressure: none; a scoreboard queue holds one expected word per driven cycle.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        FlushE;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk        (clk),
        .rst        (rst),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .RegWriteW  (RegWriteW),
        .RdW        (RdW),
        .ResultW    (ResultW),
        .FlushE     (FlushE),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .MemWriteE  (MemWriteE),
        .JumpE      (JumpE),
        .BranchE    (BranchE),
        .ALUControlE(ALUControlE),
        .ALUSrcE    (ALUSrcE),
        .RD1E       (RD1E),
        .RD2E       (RD2E),
        .ImmExtE    (ImmExtE),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .PCE        (PCE),
        .PCPlus4E   (PCPlus4E)
    );

    typedef struct packed {
        logic        regWrite;
        logic [1:0]  resultSrc;
        logic        memWrite;
        logic        jump;
        logic        branch;
        logic [2:0]  aluCtl;
        logic        aluSrc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
    } outT;

    outT         expQ[$];
    string       tagQ[$];
    logic [31:0] modelRegs [32];
    int          total = 0;
    int          bad   = 0;
    outT         act;

    assign act = outT'({RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
                        RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E});

    // Sign-extend the low 'width' bits of raw using an arithmetic shift pair.
    function automatic logic [31:0] sext(input logic [31:0] raw, input int width);
        logic signed [31:0] t;
        t = $signed(raw << (32 - width));
        return 32'(t >>> (32 - width));
    endfunction

    // Funct3-driven ALU operation for the arithmetic formats.
    function automatic logic [2:0] functOp(input logic [2:0] f3, input bit subtract);
        case (f3)
            3'b000:  return subtract ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] readModel(input logic [4:0] idx, input bit rw,
                                              input logic [4:0] rdw, input logic [31:0] resw);
        if (idx == 5'd0) return 32'd0;
        if (rw && rdw == idx) return resw;
        return modelRegs[idx];
    endfunction

    function automatic outT refModel(input bit r, input bit fl, input logic [31:0] instr,
                                     input logic [31:0] pc, input logic [31:0] rd1,
                                     input logic [31:0] rd2);
        outT e;
        e = '0;
        if (r || fl) return e;
        e.rs1 = instr[19:15];
        e.rs2 = instr[24:20];
        e.rd  = instr[11:7];
        e.rd1 = rd1;
        e.rd2 = rd2;
        e.pc  = pc;
        e.pcPlus4 = pc + 32'd4;
        case (instr[6:0])
            7'h03: begin
                e.regWrite = 1'b1; e.aluSrc = 1'b1; e.resultSrc = 2'b01;
                e.imm = sext(instr >> 20, 12);
            end
            7'h23: begin
                e.memWrite = 1'b1; e.aluSrc = 1'b1;
                e.imm = sext({20'd0, instr[31:25], instr[11:7]}, 12);
            end
            7'h33: begin
                e.regWrite = 1'b1;
                e.aluCtl = functOp(instr[14:12], instr[30]);
            end
            7'h63: begin
                e.branch = 1'b1; e.aluCtl = 3'b001;
                e.imm = sext({19'd0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, 13);
            end
            7'h13: begin
                e.regWrite = 1'b1; e.aluSrc = 1'b1;
                e.aluCtl = functOp(instr[14:12], 1'b0);
                e.imm = sext(instr >> 20, 12);
            end
            7'h6F: begin
                e.regWrite = 1'b1; e.jump = 1'b1; e.resultSrc = 2'b10;
                e.imm = sext({11'd0, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, 21);
            end
            default: e.imm = 32'd0;
        endcase
        return e;
    endfunction

    // Drive one cycle, enqueue its expected ID/EX word, then advance the register model.
    task automatic step(input string tag, input bit r, input bit fl, input logic [31:0] instr,
                        input logic [31:0] pc, input bit rw, input logic [4:0] rdw,
                        input logic [31:0] resw);
        logic [31:0] e1;
        logic [31:0] e2;
        rst = r; FlushE = fl; InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
        RegWriteW = rw; RdW = rdw; ResultW = resw;
        e1 = readModel(instr[19:15], rw, rdw, resw);
        e2 = readModel(instr[24:20], rw, rdw, resw);
        expQ.push_back(refModel(r, fl, instr, pc, e1, e2));
        tagQ.push_back(tag);
        if (r) begin
            for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
        end else if (rw && rdw != 5'd0) begin
            modelRegs[rdw] = resw;
        end
        @(negedge clk);
    endtask

    // Monitor: one ID/EX word per edge, compared against the oldest queued expectation.
    initial begin
        outT   want;
        string tag;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                want = expQ.pop_front();
                tag  = tagQ.pop_front();
                total++;
                if (act !== want) begin
                    bad++;
                    $display("FAIL %s got=%h want=%h", tag, act, want);
                end
            end
        end
    end

    initial begin
        logic [6:0]  ops [7];
        logic [31:0] rnd;
        logic [6:0]  op;
        logic [4:0]  rdw;
        ops = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h6F, 7'h7F};
        for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;

        step("rst0",        1, 0, 32'h002081B3, 32'h0,  0, 5'd0, 32'h0);
        step("rst1_nowr",   1, 0, 32'h002081B3, 32'h0,  1, 5'd5, 32'h1234);
        step("rel_add",     0, 0, 32'h002081B3, 32'h0,  0, 5'd0, 32'h0);
        step("wr_x1",       0, 0, 32'h00000013, 32'h4,  1, 5'd1, 32'h11);
        step("wr_x2",       0, 0, 32'h00000013, 32'h8,  1, 5'd2, 32'h22);
        step("bypass",      0, 0, 32'h002081B3, 32'hC,  1, 5'd1, 32'h55);
        step("x0_wr",       0, 0, 32'h00000013, 32'h10, 1, 5'd0, 32'hDEAD);
        step("x0_rd_x5",    0, 0, 32'h00500033, 32'h14, 0, 5'd0, 32'h0);
        step("lw",          0, 0, 32'hFFC0A283, 32'h18, 0, 5'd0, 32'h0);
        step("sw",          0, 0, 32'h0020A423, 32'h1C, 0, 5'd0, 32'h0);
        step("beq",         0, 0, 32'hFE208CE3, 32'h20, 0, 5'd0, 32'h0);
        step("pc",          0, 0, 32'h00000013, 32'h40, 0, 5'd0, 32'h0);
        step("flush_lw",    0, 1, 32'hFFC0A283, 32'h48, 1, 5'd7, 32'h77);
        step("after_flush", 0, 0, 32'h002381B3, 32'h4C, 0, 5'd0, 32'h0);
        step("unknown",     0, 0, 32'h0000007F, 32'h80, 0, 5'd0, 32'h0);
        step("sub",         0, 0, 32'h40208233, 32'h84, 0, 5'd0, 32'h0);
        step("jal",         0, 0, 32'h0100006F, 32'h88, 0, 5'd0, 32'h0);

        for (int n = 0; n < 600; n++) begin
            rnd = $urandom;
            op  = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            rnd[6:0] = op;
            rdw = ($urandom_range(0, 3) == 0) ? rnd[19:15] : 5'($urandom);
            step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0), rnd,
                 $urandom & 32'hFFFF_FFFC, 1'($urandom), rdw, $urandom);
        end

        repeat (2) @(posedge clk);
        #2;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Second pipeline stage of the 5-stage RV32I core. Consumes InstrD/PCD/PCPlus4D from the fetch stage and accepts write-back from WB.
- Contains the 32x32 register file (with write-first bypass), the main and ALU decoder, and the immediate extender.
- Registers everything into the ID/EX pipeline register that drives the execute stage.

Parameters:
- DATA_WIDTH, 32, datapath width. Only 32 is supported.
- REG_ADDR_W, 5, register index width. Gives 2**REG_ADDR_W registers.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- InstrD  input  32  instruction from the fetch stage
- PCD  input  32  PC of InstrD
- PCPlus4D  input  32  PCD+4
- RegWriteW  input  1  write-back enable
- RdW  input  5  write-back destination register
- ResultW  input  32  write-back data
- FlushE  input  1  clear ID/EX on the next edge (branch taken / load-use bubble)
- RegWriteE  output  1  register write enable
- ResultSrcE  output  2  result select: 00 ALU, 01 memory, 10 PC+4
- MemWriteE  output  1  store enable
- JumpE  output  1  jal
- BranchE  output  1  beq
- ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ALUSrcE  output  1  1 selects immediate
- RD1E  output  32  rs1 data
- RD2E  output  32  rs2 data
- ImmExtE  output  32  sign-extended immediate
- Rs1E  output  5  rs1 index
- Rs2E  output  5  rs2 index
- RdE  output  5  rd index
- PCE  output  32  registered PCD
- PCPlus4E  output  32  registered PCPlus4D

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high. While rst=1 at a rising edge:
  - every E output becomes 0;
  - all registers x0..x31 become 0;
  - RegWriteW is ignored that cycle.
- Reset mid-stream: the next edge after rst falls latches the current InstrD normally.
- Latency: exactly 1 cycle. Decode of InstrD at edge N appears on the E outputs after edge N.
- Register file:
  - Write on the rising edge when RegWriteW=1 and RdW!=0.
  - Writes to x0 are dropped. Reads of x0 always return 0.
  - Write-first bypass: if RegWriteW=1, RdW!=0 and RdW equals rs1 (or rs2) in the same cycle, the read returns ResultW, not the stale value.
- Fields: rs1=InstrD[19:15], rs2=InstrD[24:20], rd=InstrD[11:7]. These are captured into Rs1E/Rs2E/RdE for every opcode.
- Main decoder (opcode -> RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump):
  - 0000011 lw: 1, I, 1, 0, 01, 0, 00, 0
  - 0100011 sw: 0, S, 1, 1, xx→00, 0, 00, 0
  - 0110011 R-type: 1, -, 0, 0, 00, 0, 10, 0
  - 1100011 beq: 0, B, 0, 0, 00, 1, 01, 0
  - 0010011 I-ALU: 1, I, 1, 0, 00, 0, 10, 0
  - 1101111 jal: 1, J, 0, 0, 10, 0, 00, 1
  - Any other opcode: all control outputs 0, ALUControl 000. This is a bubble, not an error.
- ALU decoder:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10, funct3 000: sub if {op[5],funct7[5]}=11, else add.
  - ALUOp 10, funct3 010 -> slt; 110 -> or; 111 -> and.
  - ALUOp 10, other funct3 -> 000.
- Immediates, sign bit InstrD[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - J: {[31],[19:12],[20],[30:21],0}
  - R-type and unknown opcodes: ImmExtE=0.
- Flush: FlushE=1 (and rst=0) at an edge loads all-zero into ID/EX, including data, indices and PCs. rst has priority over FlushE.
- Simultaneous events:
  - FlushE does not block the register-file write; a WB write in the same cycle still commits.
  - rst does block the register-file write.

Test Plan:
- Reset: hold rst=1 for 2 edges with InstrD=0x002081B3 -> all E outputs 0. Release -> next edge gives RegWriteE=1, ALUControlE=000, Rs1E=1, Rs2E=2, RdE=3.
- Bypass: write x1=0x11 and x2=0x22 via WB. Then present add x3,x1,x2 (0x002081B3) with RegWriteW=1, RdW=1, ResultW=0x55 in the same cycle -> RD1E=0x55, RD2E=0x22.
- x0 writes: RegWriteW=1, RdW=0, ResultW=0xDEAD, then read rs1=0 -> RD1E=0.
- Immediates:
  - lw 0xFFC0A283 -> ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1.
  - sw 0x0020A423 -> ImmExtE=8, MemWriteE=1, RegWriteE=0.
  - beq 0xFE208CE3 -> ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=001.
- Flush and PC: PCD=0x40, PCPlus4D=0x44 -> PCE=0x40, PCPlus4E=0x44. Assert FlushE with lw present -> next edge all E outputs 0. Deassert -> normal decode resumes.
- Unknown opcode: InstrD=0x0000007F -> all control outputs 0 and ImmExtE=0. Rs/Rd indices and PCs still pass through.
